gctr_stream: RTL and testbench

// Parametrised GCTR engine for the GCM datapath. Runs one message of arbitrary bit length.
// For each block it requests a keystream block E(K, CB) from an external block-cipher core
// (for example PRESENT-80) over a req/ack handshake, XORs the keystream with input data,
// and emits the result. Input and output are valid/ready streams; the final partial block
// is masked and its bit count reported. Replaces the fixed 139-bit free-running GCTR.

---
 rtl/gctr_stream.sv | 124 ++++++++++++
 tb/tb_gctr_stream.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/gctr_stream.sv
// GCTR engine: per block, fetch E(K,CB) over req/ack, XOR with din, emit masked result.
// Latency 3 cycles/block minimum (REQ, DATA, OUT); dout_ready low holds OUT and blocks the next request.
module gctr_stream #(
  parameter int BLOCK_W = 64,
  parameter int INC_W   = 32,
  parameter int LEN_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [BLOCK_W-1:0] icb,
  input  logic [LEN_W-1:0]   msg_bits,
  output logic               busy,
  output logic               done,
  input  logic [BLOCK_W-1:0] din,
  input  logic               din_valid,
  output logic               din_ready,
  output logic [BLOCK_W-1:0] dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_last,
  output logic [LEN_W-1:0]   dout_nbits,
  output logic               cph_req,
  output logic [BLOCK_W-1:0] cph_blk,
  input  logic               cph_ack,
  input  logic [BLOCK_W-1:0] cph_ks
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_OUT,
    S_DONE
  } state_t;

  localparam logic [LEN_W-1:0] BW_LEN = LEN_W'(BLOCK_W);

  state_t             state, state_nxt;
  logic [BLOCK_W-1:0] ctr, ctr_inc, ks, mask;
  logic [LEN_W-1:0]   rem, nb;
  logic               is_last;

  // Only the low INC_W bits count; upper counter bits are carried through untouched.
  always_comb begin
    ctr_inc = ctr;
    ctr_inc[INC_W-1:0] = ctr[INC_W-1:0] + INC_W'(1);
  end

  always_comb begin
    nb      = (rem > BW_LEN) ? BW_LEN : rem;
    is_last = (rem <= BW_LEN);
    mask    = ~({BLOCK_W{1'b1}} >> nb);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    done       = 1'b0;
    din_ready  = 1'b0;
    dout_valid = 1'b0;
    cph_req    = 1'b0;
    cph_blk    = '0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start) state_nxt = (msg_bits == '0) ? S_DONE : S_REQ;
      end
      S_REQ: begin
        cph_req = 1'b1;
        cph_blk = ctr;
        if (cph_ack) state_nxt = S_DATA;
      end
      S_DATA: begin
        din_ready = 1'b1;
        if (din_valid) state_nxt = S_OUT;
      end
      S_OUT: begin
        dout_valid = 1'b1;
        if (dout_ready) state_nxt = dout_last ? S_DONE : S_REQ;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctr        <= '0;
      rem        <= '0;
      ks         <= '0;
      dout       <= '0;
      dout_last  <= 1'b0;
      dout_nbits <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          ctr <= icb;
          rem <= msg_bits;
        end
        S_REQ: if (cph_ack) begin
          ks  <= cph_ks;
          ctr <= ctr_inc;
        end
        S_DATA: if (din_valid) begin
          dout       <= (din ^ ks) & mask;
          dout_nbits <= nb;
          dout_last  <= is_last;
          rem        <= rem - nb;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gctr_stream.sv
// Directed bench for gctr_stream with an identity cipher core (ks = blk, ack 2 cycles after req).
module tb_gctr_stream;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] icb;
  logic [15:0] msg_bits;
  logic        busy, done;
  logic [63:0] din;
  logic        din_valid, din_ready;
  logic [63:0] dout;
  logic        dout_valid, dout_ready, dout_last;
  logic [15:0] dout_nbits;
  logic        cph_req, cph_ack;
  logic [63:0] cph_blk, cph_ks;

  int n_vec = 0;
  int n_bad = 0;

  gctr_stream #(.BLOCK_W(64), .INC_W(32), .LEN_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .icb(icb), .msg_bits(msg_bits),
    .busy(busy), .done(done), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
    .dout_nbits(dout_nbits), .cph_req(cph_req), .cph_blk(cph_blk), .cph_ack(cph_ack),
    .cph_ks(cph_ks)
  );

  always #5 clk = ~clk;

  int req_age = 0;
  always @(posedge clk) begin
    if (!cph_req || cph_ack) req_age <= 0;
    else                     req_age <= req_age + 1;
  end
  assign cph_ack = cph_req && (req_age == 2);
  assign cph_ks  = cph_blk;

  logic [63:0] od[$];
  logic [15:0] onb[$];
  logic        ol[$];
  logic [63:0] blk_q[$];
  int done_cnt = 0, n_req = 0, n_dinr = 0, n_dv = 0;

  always @(negedge clk) begin
    if (dout_valid && dout_ready) begin
      od.push_back(dout);
      onb.push_back(dout_nbits);
      ol.push_back(dout_last);
    end
    if (cph_req && cph_ack) blk_q.push_back(cph_blk);
    if (done) done_cnt++;
    if (cph_req) n_req++;
    if (din_ready) n_dinr++;
    if (dout_valid) n_dv++;
  end

  int b_out, b_blk, b_done, b_req, b_dinr, b_dv;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic outs_zero(input string tag);
    chk({tag, "_ctl"}, {58'd0, busy, done, din_ready, dout_valid, dout_last, cph_req}, 64'd0);
    chk({tag, "_dout"}, dout, 64'd0);
    chk({tag, "_nbits"}, {48'd0, dout_nbits}, 64'd0);
    chk({tag, "_blk"}, cph_blk, 64'd0);
  endtask

  task automatic snap();
    b_out  = od.size();
    b_blk  = blk_q.size();
    b_done = done_cnt;
    b_req  = n_req;
    b_dinr = n_dinr;
    b_dv   = n_dv;
  endtask

  task automatic run_msg(input logic [63:0] i, input logic [15:0] mb, input logic [63:0] d,
                         input logic rdy);
    din = d;
    din_valid = 1'b1;
    dout_ready = rdy;
    snap();
    @(posedge clk); #1;
    icb = i; msg_bits = mb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    logic seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    @(negedge clk);
  endtask

  task automatic wait_req(input string tag);
    logic seen = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (cph_req) begin
        seen = 1'b1;
        break;
      end
    end
    chk({tag, "_req_seen"}, {63'd0, seen}, 64'd1);
  endtask

  task automatic check_out(input string tag, input int k, input logic [63:0] ed,
                           input logic [15:0] en, input logic el);
    int i = b_out + k;
    if (i < od.size()) begin
      chk({tag, "_dout"}, od[i], ed);
      chk({tag, "_nbits"}, {48'd0, onb[i]}, {48'd0, en});
      chk({tag, "_last"}, {63'd0, ol[i]}, {63'd0, el});
    end else begin
      chk({tag, "_missing"}, 64'd0, 64'd1);
    end
  endtask

  task automatic check_blk(input string tag, input int k, input logic [63:0] eb);
    int i = b_blk + k;
    if (i < blk_q.size()) chk(tag, blk_q[i], eb);
    else                  chk({tag, "_missing"}, 64'd0, 64'd1);
  endtask

  task automatic check_139(input string tag);
    chk({tag, "_nout"}, 64'(od.size() - b_out), 64'd3);
    check_out({tag, "_b0"}, 0, 64'hABAC8CA6000AA98A, 16'd64, 1'b0);
    check_out({tag, "_b1"}, 1, 64'hABAC8CA6000AA98B, 16'd64, 1'b0);
    check_out({tag, "_b2"}, 2, 64'hABA0000000000000, 16'd11, 1'b1);
    check_blk({tag, "_blk2"}, 2, 64'hABAC8CA6000AA98C);
    chk({tag, "_ndone"}, 64'(done_cnt - b_done), 64'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; icb = '0; msg_bits = '0;
    din = '0; din_valid = 1'b0; dout_ready = 1'b0;
    #2;
    outs_zero("t0_reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // 1: 139-bit message, partial final block of 11 bits
    run_msg(64'hABAC8CA6000AA98A, 16'd139, 64'd0, 1'b1);
    wait_done("t1");
    check_139("t1");

    // 2: low 32 bits wrap, upper half untouched; din exercises the XOR
    run_msg(64'h12345678FFFFFFFF, 16'd128, 64'h00000000FFFFFFFF, 1'b1);
    wait_done("t2");
    check_blk("t2_blk0", 0, 64'h12345678FFFFFFFF);
    check_blk("t2_blk1", 1, 64'h1234567800000000);
    check_out("t2_b0", 0, 64'h1234567800000000, 16'd64, 1'b0);
    check_out("t2_b1", 1, 64'h12345678FFFFFFFF, 16'd64, 1'b1);

    // 3: empty message goes straight to DONE
    run_msg(64'hABAC8CA6000AA98A, 16'd0, 64'd0, 1'b1);
    @(negedge clk);
    chk("t3_done_hi", {63'd0, done}, 64'd1);
    @(negedge clk);
    chk("t3_done_lo", {63'd0, done}, 64'd0);
    chk("t3_busy", {63'd0, busy}, 64'd0);
    chk("t3_activity", 64'((n_req - b_req) + (n_dinr - b_dinr) + (n_dv - b_dv)), 64'd0);

    // 4: output stall holds the block and suppresses the next request
    run_msg(64'hABAC8CA6000AA98A, 16'd128, 64'd0, 1'b0);
    begin
      logic seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (dout_valid) begin
          seen = 1'b1;
          break;
        end
      end
      chk("t4_valid_seen", {63'd0, seen}, 64'd1);
    end
    for (int s = 0; s < 5; s++) begin
      chk("t4_hold_dout", dout, 64'hABAC8CA6000AA98A);
      chk("t4_hold_dinr", {63'd0, din_ready}, 64'd0);
      chk("t4_hold_req", {63'd0, cph_req}, 64'd0);
      @(negedge clk);
    end
    @(posedge clk); #1;
    dout_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t4_resume_req", {63'd0, cph_req}, 64'd1);
    wait_done("t4");
    check_out("t4_b0", 0, 64'hABAC8CA6000AA98A, 16'd64, 1'b0);
    check_out("t4_b1", 1, 64'hABAC8CA6000AA98B, 16'd64, 1'b1);

    // 5: asynchronous reset mid-request aborts without done
    run_msg(64'hABAC8CA6000AA98A, 16'd64, 64'd0, 1'b1);
    wait_req("t5");
    #2;
    reset = 1'b1;
    #1;
    outs_zero("t5_abort");
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("t5_no_done", 64'(done_cnt - b_done), 64'd0);
    run_msg(64'hABAC8CA6000AA98A, 16'd64, 64'd0, 1'b1);
    wait_done("t5");
    chk("t5_nout", 64'(od.size() - b_out), 64'd1);
    check_out("t5_b0", 0, 64'hABAC8CA6000AA98A, 16'd64, 1'b1);

    // 6: start while busy is ignored
    run_msg(64'hABAC8CA6000AA98A, 16'd139, 64'd0, 1'b1);
    wait_req("t6");
    @(posedge clk); #1;
    icb = 64'h1111111111111111; msg_bits = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t6");
    check_139("t6");
    check_blk("t6_blk0", 0, 64'hABAC8CA6000AA98A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
